regfile_host_if: RTL

REGFILE_HOST_IF -- requirements
Module: regfile_host_if

---
 rtl/regfile_host_if.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/regfile_host_if.sv
// Byte-stream host interface to a register file.
// Commands: 0x57 addr data -> write, ACK 0xAC; 0x52 addr -> read, returns data;
// any other opcode -> NAK 0xEE. A stalled command is aborted after TIMEOUT_CYCLES
// idle cycles between bytes.
module regfile_host_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] rf_addr,
  output logic [7:0] rf_din,
  output logic       rf_wen,
  output logic       rf_ren,
  input  logic [7:0] rf_dout,
  output logic       timeout
);

  localparam logic [7:0] OpWrite = 8'h57;
  localparam logic [7:0] OpRead  = 8'h52;
  localparam logic [7:0] RespAck = 8'hAC;
  localparam logic [7:0] RespNak = 8'hEE;
  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StWrite,
    StRead,
    StResp
  } state_e;

  state_e     state_q, state_d;
  logic       op_wr_q, op_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] resp_q, resp_d;
  logic [7:0] cnt_q, cnt_d;

  logic       accepting;
  logic       in_xfer;
  logic       wen_int;
  logic       ren_int;
  logic       tout_int;
  logic [8:0] cnt_inc;

  assign accepting = (state_q == StIdle) || (state_q == StGetAddr) || (state_q == StGetData);
  assign in_xfer   = in_valid && accepting;
  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_wr_q <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      resp_q  <= 8'h00;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, latch enables, strobes and inter-byte timeout.
  always_comb begin
    state_d  = state_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    resp_d   = resp_q;
    cnt_d    = 8'h00;
    wen_int  = 1'b0;
    ren_int  = 1'b0;
    tout_int = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          if (in_data == OpWrite) begin
            op_wr_d = 1'b1;
            state_d = StGetAddr;
          end else if (in_data == OpRead) begin
            op_wr_d = 1'b0;
            state_d = StGetAddr;
          end else begin
            resp_d  = RespNak;
            state_d = StResp;
          end
        end
      end
      StGetAddr, StGetData: begin
        if (in_xfer) begin
          if (state_q == StGetAddr) begin
            addr_d  = in_data;
            state_d = op_wr_q ? StGetData : StRead;
          end else begin
            data_d  = in_data;
            state_d = StWrite;
          end
        end else if (cnt_inc >= TimeoutLim) begin
          // Abort silently: no register access, no response.
          tout_int = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_inc[8] ? 8'hFF : cnt_inc[7:0];
        end
      end
      StWrite: begin
        wen_int = 1'b1;
        resp_d  = RespAck;
        state_d = StResp;
      end
      StRead: begin
        ren_int = 1'b1;
        resp_d  = rf_dout;
        state_d = StResp;
      end
      StResp: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced to reset values while rst is high so a stale state
  // never leaks a strobe or response during reset.
  always_comb begin
    in_ready  = !rst && accepting;
    out_valid = !rst && (state_q == StResp);
    out_data  = rst ? 8'h00 : resp_q;
    rf_addr   = rst ? 8'h00 : addr_q;
    rf_din    = rst ? 8'h00 : data_q;
    rf_wen    = !rst && wen_int;
    rf_ren    = !rst && ren_int;
    timeout   = !rst && tout_int;
  end

endmodule
